// File: rtl/piso_serializer_if.sv
// Parallel word handshake between a sender and the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] parallel_in;
  logic             in_valid;
  logic             in_ready;

  modport master (output parallel_in, output in_valid, input in_ready);
  modport slave  (input parallel_in, input in_valid, output in_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a 1-entry holding buffer so that
// back-to-back words leave the link as one continuous frame.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus,
  output logic              serial_out,
  output logic              frame,
  output logic              last_bit,
  output logic              busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic             shifter_free;
  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  // Bit that goes on the wire next from a given word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Shifter can take a new word on this edge: idle, or current bit is the last one.
  assign shifter_free = (state == IDLE) || (cnt == LAST_CNT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_word    = hold_full ? hold : bus.parallel_in;
  assign load_en      = shifter_free && (hold_full || accept);

  assign bus.in_ready = !hold_full && !rst;
  assign busy         = (state == SHIFT) || hold_full;

  // shreg holds the bits still to be sent; serial_out is the bit currently on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      serial_out <= 1'b0;
      frame      <= 1'b0;
      last_bit   <= 1'b0;
    end else if (load_en) begin
      state      <= SHIFT;
      cnt        <= '0;
      shreg      <= shift_word(load_word);
      serial_out <= first_bit(load_word);
      frame      <= 1'b1;
      last_bit   <= 1'b0;
      hold_full  <= 1'b0;
    end else if (state == SHIFT && !shifter_free) begin
      cnt        <= cnt + CNT_W'(1);
      shreg      <= shift_word(shreg);
      serial_out <= first_bit(shreg);
      last_bit   <= ((cnt + CNT_W'(1)) == LAST_CNT);
      if (accept) begin
        hold      <= bus.parallel_in;
        hold_full <= 1'b1;
      end
    end else begin
      state      <= IDLE;
      cnt        <= '0;
      serial_out <= 1'b0;
      frame      <= 1'b0;
      last_bit   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// driven by the same stimulus.
module tb_piso_serializer;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             vin;

  logic m_ser, m_frame, m_last, m_busy;
  logic l_ser, l_frame, l_last, l_busy;

  int total = 0;
  int bad   = 0;

  piso_serializer_if #(.WIDTH(WIDTH)) if_m ();
  piso_serializer_if #(.WIDTH(WIDTH)) if_l ();

  assign if_m.parallel_in = din;
  assign if_m.in_valid    = vin;
  assign if_l.parallel_in = din;
  assign if_l.in_valid    = vin;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(if_m.slave),
    .serial_out(m_ser), .frame(m_frame), .last_bit(m_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l.slave),
    .serial_out(l_ser), .frame(l_frame), .last_bit(l_last), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  exp_m;
    logic [3:0]  exp_l;
    logic [3:0]  exp_last;
    logic [11:0] stream;
    logic [3:0]  ready_a;
    logic [3:0]  ready_b;

    clk = 1'b0;
    rst = 1'b1;
    din = '0;
    vin = 1'b0;

    // Reset held for two edges
    tick();
    tick();
    check("rst_ready", if_m.in_ready, 1'b0);
    check("rst_frame", m_frame, 1'b0);
    check("rst_ser",   m_ser,   1'b0);
    check("rst_busy",  m_busy,  1'b0);
    rst = 1'b0;
    tick();
    check("idle_ready", if_m.in_ready, 1'b1);
    check("idle_frame", m_frame, 1'b0);
    check("idle_ser",   m_ser,   1'b0);
    check("idle_busy",  m_busy,  1'b0);

    // Single word 1101, both bit orders
    exp_m    = 4'b1101;
    exp_l    = 4'b1011;
    exp_last = 4'b0001;
    din = 4'b1101;
    vin = 1'b1;
    tick();
    vin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("single_m_ser%0d", k),  m_ser,   exp_m[3-k]);
      check($sformatf("single_l_ser%0d", k),  l_ser,   exp_l[3-k]);
      check($sformatf("single_frame%0d", k),  m_frame, 1'b1);
      check($sformatf("single_lframe%0d", k), l_frame, 1'b1);
      check($sformatf("single_last%0d", k),   m_last,  exp_last[3-k]);
      check($sformatf("single_llast%0d", k),  l_last,  exp_last[3-k]);
      tick();
    end
    check("single_end_frame", m_frame, 1'b0);
    check("single_end_ser",   m_ser,   1'b0);
    check("single_end_last",  m_last,  1'b0);
    check("single_end_busy",  m_busy,  1'b0);
    check("single_end_lframe", l_frame, 1'b0);

    // Three back-to-back words 1101, 1001, 0110 as one 12-bit frame
    stream  = 12'b1101_1001_0110;
    ready_a = 4'b1000;
    ready_b = 4'b1000;
    din = 4'b1101;
    vin = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("b2b_ser%0d", k),   m_ser,   stream[11-k]);
      check($sformatf("b2b_frame%0d", k), m_frame, 1'b1);
      check($sformatf("b2b_last%0d", k),  m_last,  (k % 4) == 3);
      check($sformatf("b2b_busy%0d", k),  m_busy,  1'b1);
      if (k < 4)
        check($sformatf("b2b_ready%0d", k), if_m.in_ready, ready_a[3-k]);
      else if (k < 8)
        check($sformatf("b2b_ready%0d", k), if_m.in_ready, ready_b[3-(k-4)]);
      else
        check($sformatf("b2b_ready%0d", k), if_m.in_ready, 1'b1);
      if (k == 0) din = 4'b1001;
      if (k == 1) din = 4'b0110;
      if (k == 4) vin = 1'b1;
      if (k == 5) vin = 1'b0;
      tick();
    end
    check("b2b_end_frame", m_frame, 1'b0);
    check("b2b_end_ser",   m_ser,   1'b0);
    check("b2b_end_busy",  m_busy,  1'b0);

    // Reset on the 2nd bit of 1011 while 0110 sits in the holding buffer
    din = 4'b1011;
    vin = 1'b1;
    tick();
    check("abort_ser0", m_ser, 1'b1);
    din = 4'b0110;
    tick();
    check("abort_ser1",   m_ser,         1'b0);
    check("abort_ready1", if_m.in_ready, 1'b0);
    check("abort_busy1",  m_busy,        1'b1);
    rst = 1'b1;
    vin = 1'b0;
    tick();
    check("abort_frame", m_frame, 1'b0);
    check("abort_ser",   m_ser,   1'b0);
    check("abort_busy",  m_busy,  1'b0);
    check("abort_ready_rst", if_m.in_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("abort_ready", if_m.in_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_quiet_frame%0d", k), m_frame, 1'b0);
      check($sformatf("abort_quiet_ser%0d", k),   m_ser,   1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
